// File: rtl/lcd_char_render.sv
// Renders one font glyph into an LCD window over a byte-wide writer, re-arming forever once flagged.
// Optional panel window offset (+1 column, +2 row) is enabled by defining LCD_CHAR_OFFSET_EN.
module lcd_char_render (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        show_char_flag,
    input  logic [7:0]  ascii_num,
    input  logic [8:0]  start_x,
    input  logic [8:0]  start_y,
    input  logic        en_size,
    input  logic [15:0] front_color,
    input  logic [15:0] background_color,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        rom_sel,
    output logic        wr_req,
    output logic [8:0]  wr_data,
    input  logic        wr_done,
    output logic        show_char_done
);
    typedef enum logic [2:0] {IDLE, GAP, LATCH, CMD, ROM_RD, PIX_HI, PIX_LO, DONE} state_t;
    state_t state, state_next;

    logic [7:0]  idx_q;
    logic [8:0]  sx_q, sy_q;
    logic        big_q;
    logic [15:0] fc_q, bc_q;
    logic [3:0]  byte_q, row_q;
    logic [2:0]  col_q;
    logic        gap_q, rd_phase_q, sent_q;
    logic [7:0]  bits_q;

    logic        byte_done, last_col, last_row, pix_on;
    logic [8:0]  xs, xe, ys, ye;
    logic [15:0] color;
    logic [10:0] idx_ext, row_ext;

`ifdef LCD_CHAR_OFFSET_EN
    assign xs = sx_q + 9'd1;
    assign ys = sy_q + 9'd2;
`else
    assign xs = sx_q;
    assign ys = sy_q;
`endif
    assign xe = xs + (big_q ? 9'd7 : 9'd5);
    assign ye = ys + (big_q ? 9'd15 : 9'd11);

    // A wr_done only counts once our request is outstanding.
    assign byte_done = sent_q & wr_done;
    assign last_col  = (col_q == (big_q ? 3'd7 : 3'd5));
    assign last_row  = (row_q == (big_q ? 4'd15 : 4'd11));
    assign pix_on    = (idx_q <= 8'd94) && bits_q[3'd7 - col_q];
    assign color     = pix_on ? fc_q : bc_q;

    assign idx_ext  = {3'b000, idx_q};
    assign row_ext  = {7'b0000000, row_q};
    assign rom_addr = big_q ? (idx_ext << 4) + row_ext
                            : (idx_ext << 3) + (idx_ext << 2) + row_ext;
    assign rom_sel  = big_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (show_char_flag) state_next = GAP;
            GAP:     if (gap_q) state_next = LATCH;
            LATCH:   state_next = CMD;
            CMD:     if (byte_done && byte_q == 4'd10) state_next = ROM_RD;
            ROM_RD:  if (rd_phase_q) state_next = PIX_HI;
            PIX_HI:  if (byte_done) state_next = PIX_LO;
            PIX_LO:
                if (byte_done) begin
                    if (!last_col)     state_next = PIX_HI;
                    else if (last_row) state_next = DONE;
                    else               state_next = ROM_RD;
                end
            DONE:    state_next = GAP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            big_q      <= 1'b0;
            fc_q       <= '0;
            bc_q       <= '0;
            byte_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            gap_q      <= 1'b0;
            rd_phase_q <= 1'b0;
            sent_q     <= 1'b0;
            bits_q     <= '0;
        end else begin
            if (byte_done)   sent_q <= 1'b0;
            else if (wr_req) sent_q <= 1'b1;
            gap_q      <= (state == GAP) ? ~gap_q : 1'b0;
            rd_phase_q <= (state == ROM_RD) ? ~rd_phase_q : 1'b0;
            case (state)
                LATCH: begin
                    idx_q  <= ascii_num;
                    sx_q   <= start_x;
                    sy_q   <= start_y;
                    big_q  <= en_size;
                    fc_q   <= front_color;
                    bc_q   <= background_color;
                    byte_q <= '0;
                    row_q  <= '0;
                    col_q  <= '0;
                end
                CMD:    if (byte_done) byte_q <= byte_q + 4'd1;
                ROM_RD: if (rd_phase_q) bits_q <= rom_data;
                PIX_LO:
                    if (byte_done) begin
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + 4'd1;
                        end else begin
                            col_q <= col_q + 3'd1;
                        end
                    end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_req         = 1'b0;
        wr_data        = '0;
        show_char_done = 1'b0;
        case (state)
            CMD: begin
                wr_req = ~sent_q;
                case (byte_q)
                    4'd0:    wr_data = {1'b0, 8'h2A};
                    4'd1:    wr_data = {1'b1, 7'b0000000, xs[8]};
                    4'd2:    wr_data = {1'b1, xs[7:0]};
                    4'd3:    wr_data = {1'b1, 7'b0000000, xe[8]};
                    4'd4:    wr_data = {1'b1, xe[7:0]};
                    4'd5:    wr_data = {1'b0, 8'h2B};
                    4'd6:    wr_data = {1'b1, 7'b0000000, ys[8]};
                    4'd7:    wr_data = {1'b1, ys[7:0]};
                    4'd8:    wr_data = {1'b1, 7'b0000000, ye[8]};
                    4'd9:    wr_data = {1'b1, ye[7:0]};
                    default: wr_data = {1'b0, 8'h2C};
                endcase
            end
            PIX_HI: begin
                wr_req  = ~sent_q;
                wr_data = {1'b1, color[15:8]};
            end
            PIX_LO: begin
                wr_req  = ~sent_q;
                wr_data = {1'b1, color[7:0]};
            end
            DONE:    show_char_done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lcd_char_render.sv
// Self-checking bench for lcd_char_render: randomized characters against a byte-stream reference model.
`timescale 1ns/1ps
module tb_lcd_char_render;
`ifdef LCD_CHAR_OFFSET_EN
    localparam int OX = 1;
    localparam int OY = 2;
`else
    localparam int OX = 0;
    localparam int OY = 0;
`endif

    logic        sys_clk, sys_rst_n, show_char_flag;
    logic [7:0]  ascii_num;
    logic [8:0]  start_x, start_y;
    logic        en_size;
    logic [15:0] front_color, background_color;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_sel, wr_req;
    logic [8:0]  wr_data;
    logic        wr_done, show_char_done;

    typedef struct {
        int idx; int sx; int sy; int big; int fc; int bc; int dly;
    } cfg_t;

    int checks = 0;
    int errors = 0;
    int proto_err = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int first_req_cyc = 0;
    int flag_cyc = 0;
    int cyc = 0;
    int dly = 3;
    bit spur_en = 0;
    logic [7:0] rom [0:2047];
    logic [8:0] got[$];
    logic [8:0] cur[$];
    logic [8:0] exp_q[$];
    cfg_t cfg[12];

    lcd_char_render dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .show_char_flag   (show_char_flag),
        .ascii_num        (ascii_num),
        .start_x          (start_x),
        .start_y          (start_y),
        .en_size          (en_size),
        .front_color      (front_color),
        .background_color (background_color),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .rom_sel          (rom_sel),
        .wr_req           (wr_req),
        .wr_data          (wr_data),
        .wr_done          (wr_done),
        .show_char_done   (show_char_done)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Font ROM with one-cycle read latency.
    always @(posedge sys_clk) rom_data <= rom[rom_addr];

    initial begin
        #3000000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    // Writer model: answers each request after dly cycles, sometimes pulses wr_done unprompted.
    initial begin : responder
        int cnt;
        cnt = 0;
        wr_done = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            wr_done = 1'b0;
            if (!sys_rst_n) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) wr_done = 1'b1;
            end else if (wr_req) cnt = dly;
            else if (spur_en && $urandom_range(0, 5) == 0) wr_done = 1'b1;
        end
    end

    initial begin : monitor
        bit outstanding;
        bit prev_done;
        logic [8:0] held;
        outstanding = 0;
        prev_done = 0;
        held = '0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (!sys_rst_n) begin
                outstanding = 0;
                prev_done = 0;
            end else begin
                if (show_char_flag) flag_cyc = cyc;
                if (wr_req) begin
                    if (outstanding) proto_err++;
                    if (got.size() == 0) first_req_cyc = cyc;
                    got.push_back(wr_data);
                    held = wr_data;
                    outstanding = 1;
                end else if (outstanding) begin
                    if (wr_data !== held) proto_err++;
                    if (wr_done) outstanding = 0;
                end
                if (show_char_done) begin
                    if (prev_done) proto_err++;
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_done = show_char_done;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] cur_at(input int i);
        if (i < cur.size()) return {23'd0, cur[i]};
        return 32'hDEAD;
    endfunction

    task automatic push_coord(input int v);
        exp_q.push_back(9'(256 + v / 256));
        exp_q.push_back(9'(256 + v % 256));
    endtask

    // Reference stream straight from the rules: window commands then W*H pixels, two bytes each.
    task automatic build_exp(input cfg_t c);
        int w, h, xs, ys, rb, colr;
        w  = c.big ? 8 : 6;
        h  = c.big ? 16 : 12;
        xs = (c.sx + OX) % 512;
        ys = (c.sy + OY) % 512;
        exp_q.delete();
        exp_q.push_back(9'h02A);
        push_coord(xs);
        push_coord((xs + w - 1) % 512);
        exp_q.push_back(9'h02B);
        push_coord(ys);
        push_coord((ys + h - 1) % 512);
        exp_q.push_back(9'h02C);
        for (int r = 0; r < h; r++) begin
            rb = (c.idx <= 94) ? int'(rom[(c.idx * h + r) % 2048]) : 0;
            for (int p = 0; p < w; p++) begin
                colr = ((rb >> (7 - p)) & 1) ? c.fc : c.bc;
                push_coord(colr);
            end
        end
    endtask

    task automatic apply_cfg(input cfg_t c);
        ascii_num        = 8'(c.idx);
        start_x          = 9'(c.sx);
        start_y          = 9'(c.sy);
        en_size          = (c.big != 0);
        front_color      = 16'(c.fc);
        background_color = 16'(c.bc);
        dly              = c.dly;
    endtask

    task automatic scramble;
        ascii_num        = 8'($urandom);
        start_x          = 9'($urandom);
        start_y          = 9'($urandom);
        en_size          = 1'($urandom);
        front_color      = 16'($urandom);
        background_color = 16'($urandom);
    endtask

    task automatic pulse_flag;
        show_char_flag = 1'b1;
        @(posedge sys_clk);
        #2;
        show_char_flag = 1'b0;
    endtask

    task automatic wait_first_req(input string tag);
        int n;
        n = 0;
        while (got.size() == 0 && n < 200) begin
            @(posedge sys_clk);
            #2;
            n++;
        end
        check({tag, "_start"}, 32'(got.size() > 0), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int base, n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < 4000) begin
            @(posedge sys_clk);
            #2;
            n++;
        end
        check({tag, "_done"}, 32'(done_cnt != base), 32'd1);
        cur = got;
        got.delete();
    endtask

    task automatic compare_char(input cfg_t c, input string tag);
        int mism, n;
        build_exp(c);
        check({tag, "_len"}, cur.size(), exp_q.size());
        n = (cur.size() < exp_q.size()) ? cur.size() : exp_q.size();
        mism = 0;
        for (int i = 0; i < n; i++) begin
            if (cur[i] !== exp_q[i]) begin
                if (mism == 0)
                    $display("%s first difference at byte %0d: got %h want %h", tag, i, cur[i], exp_q[i]);
                mism++;
            end
        end
        check({tag, "_bytes"}, mism, 0);
        check({tag, "_rom_sel"}, 32'(rom_sel), 32'(c.big));
    endtask

    initial begin : main
        int arm, prev_done, bad, n;
        string nm;
        logic [8:0] hdr [11];
        logic [7:0] pat [16];

        for (int a = 0; a < 2048; a++) rom[a] = 8'($urandom);
        rom[33 * 16] = 8'hA5;

        cfg[0] = '{45, 60, 0, 1, 'hF800, 'h001F, 3};
        cfg[1] = '{$urandom_range(0, 94), 256, 100, 0, $urandom_range(0, 65535), $urandom_range(0, 65535), 2};
        cfg[2] = '{33, $urandom_range(0, 511), $urandom_range(0, 511), 1, 'h0000, 'hFFFF, 1};
        cfg[3] = '{120, 0, 0, $urandom_range(0, 1), $urandom_range(0, 65535), $urandom_range(0, 65535), 4};
        cfg[4] = '{10, $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 1),
                   $urandom_range(0, 65535), $urandom_range(0, 65535), 2};
        for (int i = 5; i < 12; i++)
            cfg[i] = '{$urandom_range(0, 127), $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 1),
                       $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(1, 4)};
        cfg[10].big = 1;

        sys_rst_n = 1'b0;
        show_char_flag = 1'b0;
        scramble();
        repeat (3) @(posedge sys_clk);
        #2;
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_sel", 32'(rom_sel), 32'd0);
        check("rst_done", 32'(show_char_done), 32'd0);
        sys_rst_n = 1'b1;
        spur_en = 1;
        repeat (10) @(posedge sys_clk);
        #2;
        check("idle_quiet", got.size(), 0);
        spur_en = 0;

        apply_cfg(cfg[0]);
        pulse_flag();
        arm = flag_cyc;
        prev_done = 0;
        for (int i = 0; i < 10; i++) begin
            nm = $sformatf("c%0d", i);
            wait_first_req(nm);
            if (i == 0) check("arm_latency", first_req_cyc - arm, 4);
            else        check({nm, "_relatch_latency"}, first_req_cyc - prev_done, 4);
            scramble();
            if (i >= 1) pulse_flag();
            wait_done(nm);
            prev_done = done_cyc;
            apply_cfg(cfg[i + 1]);
            spur_en = (i + 1 >= 4);
            compare_char(cfg[i], nm);
            if (i == 0) begin
                hdr = '{9'h02A, 9'h100, 9'(256 + 60 + OX), 9'h100, 9'(256 + 67 + OX), 9'h02B,
                        9'h100, 9'(256 + OY), 9'h100, 9'(256 + 15 + OY), 9'h02C};
                for (int k = 0; k < 11; k++)
                    check($sformatf("m_hdr%0d", k), cur_at(k), {23'd0, hdr[k]});
                check("m_total", cur.size(), 267);
            end else if (i == 1) begin
                check("s_xs_hi", cur_at(1), 32'h101);
                check("s_xs_lo", cur_at(2), 32'(256 + OX));
                check("s_xe_lo", cur_at(4), 32'(256 + 5 + OX));
                check("s_ye_lo", cur_at(9), 32'(256 + 111 + OY));
                check("s_total", cur.size(), 155);
            end else if (i == 2) begin
                pat = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF,
                        8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
                for (int k = 0; k < 16; k++)
                    check($sformatf("a5_pix%0d", k), cur_at(11 + k), {23'd0, 1'b1, pat[k]});
            end else if (i == 3) begin
                bad = 0;
                for (int k = 11; k + 1 < cur.size(); k += 2)
                    if ({cur[k][7:0], cur[k + 1][7:0]} !== 16'(cfg[3].bc)) bad++;
                check("oor_background", bad, 0);
                check("origin_xs_lo", cur_at(2), 32'(256 + OX));
                check("origin_ys_lo", cur_at(7), 32'(256 + OY));
            end
        end

        n = 0;
        while (!(wr_req === 1'b1 && got.size() == 99) && n < 3000) begin
            @(posedge sys_clk);
            #2;
            n++;
        end
        check("rst_reach_byte100", 32'(wr_req === 1'b1 && got.size() == 99), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_wr_req", 32'(wr_req), 32'd0);
        check("mid_rst_wr_data", 32'(wr_data), 32'd0);
        check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("mid_rst_rom_sel", 32'(rom_sel), 32'd0);
        check("mid_rst_done", 32'(show_char_done), 32'd0);
        got.delete();
        repeat (4) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        spur_en = 1;
        repeat (60) @(posedge sys_clk);
        #2;
        check("post_rst_quiet", got.size(), 0);

        apply_cfg(cfg[11]);
        pulse_flag();
        arm = flag_cyc;
        wait_first_req("after_rst");
        check("after_rst_latency", first_req_cyc - arm, 4);
        scramble();
        wait_done("after_rst");
        compare_char(cfg[11], "after_rst");

        check("protocol", proto_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
